// File: rtl/aes_pkg.sv
// AES helper package: FSM state type, GF(2^8) arithmetic, S-box and inverse S-box
// (computed via field inversion plus affine map), column mixing, row shifting and Rcon.
// State layout: byte 0 is bits [127:120]; byte k = row (k % 4), column (k / 4).
package aes_pkg;

    typedef enum logic [2:0] {
        StNoKey,
        StKeySetup,
        StIdle,
        StRun,
        StHold
    } aes_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*((c+r)%4)) -: 8] = s[127-8*(r+4*c) -: 8];
        return o;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_column(s[127-32*c -: 32]);
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] j);
        case (j)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_key_sched_seq.sv
// Sequential AES key expansion: one schedule word per cycle into a 4*(Nr+1) x 32 store.
// Ports: start_i loads key_i into w[0..Nk-1] and (re)starts expansion; done_o pulses in the
// cycle the last word is written; rd_round_i selects round key rd_key_o (combinational).
module aes_key_sched_seq
    import aes_pkg::*;
#(
    parameter int unsigned Nk = 4
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            start_i,
    input  logic [32*Nk-1:0] key_i,
    output logic            done_o,
    input  logic [3:0]      rd_round_i,
    output logic [127:0]    rd_key_o
);
    localparam int unsigned Nr = Nk + 6;
    localparam int unsigned Nw = 4 * (Nr + 1);

    logic [31:0] w_q [Nw];
    logic [31:0] w_d [Nw];
    logic        busy_q, busy_d;
    logic [5:0]  i_q, i_d;     // index of the word being generated
    logic [2:0]  k_q, k_d;     // i mod Nk
    logic [3:0]  j_q, j_d;     // i / Nk, selects Rcon
    logic [31:0] prev, older, temp;

    always_comb begin
        prev  = w_q[i_q - 6'd1];
        older = w_q[i_q - 6'(Nk)];
        temp  = prev;
        if (k_q == 3'd0) begin
            temp = sub_word({prev[23:0], prev[31:24]}) ^ {rcon(j_q), 24'h0};
        end else if ((Nk == 8) && (k_q == 3'd4)) begin
            temp = sub_word(prev);
        end

        w_d    = w_q;
        busy_d = busy_q;
        i_d    = i_q;
        k_d    = k_q;
        j_d    = j_q;
        done_o = 1'b0;
        if (start_i) begin
            for (int j = 0; j < Nk; j++) w_d[j] = key_i[32*(Nk-j)-1 -: 32];
            busy_d = 1'b1;
            i_d    = 6'(Nk);
            k_d    = 3'd0;
            j_d    = 4'd1;
        end else if (busy_q) begin
            w_d[i_q] = older ^ temp;
            i_d      = i_q + 6'd1;
            k_d      = (k_q == 3'(Nk - 1)) ? 3'd0 : k_q + 3'd1;
            j_d      = (k_q == 3'(Nk - 1)) ? j_q + 4'd1 : j_q;
            if (i_q == 6'(Nw - 1)) begin
                busy_d = 1'b0;
                done_o = 1'b1;
            end
        end
    end

    assign rd_key_o = {w_q[{rd_round_i, 2'b00}], w_q[{rd_round_i, 2'b01}],
                       w_q[{rd_round_i, 2'b10}], w_q[{rd_round_i, 2'b11}]};

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int j = 0; j < Nw; j++) w_q[j] <= '0;
            busy_q <= 1'b0;
            i_q    <= '0;
            k_q    <= '0;
            j_q    <= '0;
        end else begin
            w_q    <= w_d;
            busy_q <= busy_d;
            i_q    <= i_d;
            k_q    <= k_d;
            j_q    <= j_d;
        end
    end

endmodule

// File: rtl/aes_core_iter.sv
// Iterative AES core, one round per clock, encrypt or decrypt chosen per block.
// Ports: key_load/key start key setup, key_ready flags a valid round-key store;
// in_valid/in_ready/in_decrypt/in_data accept a block; out_valid/out_ready/out_decrypt/out_data
// present the result, held stable until consumed.
module aes_core_iter
    import aes_pkg::*;
#(
    parameter int unsigned Nk = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             key_load,
    input  logic [32*Nk-1:0] key,
    output logic             key_ready,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_decrypt,
    input  logic [127:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_decrypt,
    output logic [127:0]     out_data
);
    localparam int unsigned Nr = Nk + 6;

    if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
        $error("aes_core_iter: Nk must be 4, 6 or 8");
    end

    aes_state_e   state_q, state_d;
    logic [127:0] st_q, st_d;
    logic         dec_q, dec_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] out_data_q, out_data_d;
    logic         out_dec_q, out_dec_d;

    logic         ks_start, ks_done, accept, last_rnd;
    logic [3:0]   rk_idx;
    logic [127:0] rk, enc_t, dec_t, enc_res, dec_res, rnd_res;

    aes_key_sched_seq #(.Nk(Nk)) u_key_sched (
        .clk       (clk),
        .rst_b     (rst_b),
        .start_i   (ks_start),
        .key_i     (key),
        .done_o    (ks_done),
        .rd_round_i(rk_idx),
        .rd_key_o  (rk)
    );

    always_comb begin
        key_ready = (state_q == StIdle) || (state_q == StRun) || (state_q == StHold);
        in_ready  = ((state_q == StIdle) && !key_load) || ((state_q == StHold) && out_ready);
        out_valid = (state_q == StHold);
        accept    = in_valid && in_ready;
        // Outside RUN the only key needed is the whitening key of a block being accepted.
        rk_idx    = (state_q == StRun) ? rnd_q : (in_decrypt ? 4'(Nr) : 4'd0);

        enc_t    = shift_rows(sub_bytes(st_q));
        enc_res  = ((rnd_q == 4'(Nr)) ? enc_t : mix_columns(enc_t)) ^ rk;
        dec_t    = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk;
        dec_res  = (rnd_q == 4'd0) ? dec_t : inv_mix_columns(dec_t);
        rnd_res  = dec_q ? dec_res : enc_res;
        last_rnd = dec_q ? (rnd_q == 4'd0) : (rnd_q == 4'(Nr));

        state_d    = state_q;
        st_d       = st_q;
        dec_d      = dec_q;
        rnd_d      = rnd_q;
        out_data_d = out_data_q;
        out_dec_d  = out_dec_q;
        ks_start   = 1'b0;

        unique case (state_q)
            StNoKey, StKeySetup, StIdle: begin
                if (key_load) begin
                    ks_start = 1'b1;
                    state_d  = StKeySetup;
                end else if ((state_q == StKeySetup) && ks_done) begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                st_d  = rnd_res;
                rnd_d = dec_q ? rnd_q - 4'd1 : rnd_q + 4'd1;
                if (last_rnd) begin
                    out_data_d = rnd_res;
                    out_dec_d  = dec_q;
                    state_d    = StHold;
                end
            end
            StHold: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StNoKey;
        endcase

        // Accept overrides the IDLE/HOLD decision above; key_load already masks in_ready.
        if (accept) begin
            st_d    = in_data ^ rk;
            dec_d   = in_decrypt;
            rnd_d   = in_decrypt ? 4'(Nr - 1) : 4'd1;
            state_d = StRun;
        end
    end

    assign out_data    = out_data_q;
    assign out_decrypt = out_dec_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= StNoKey;
            st_q       <= '0;
            dec_q      <= 1'b0;
            rnd_q      <= '0;
            out_data_q <= '0;
            out_dec_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            st_q       <= st_d;
            dec_q      <= dec_d;
            rnd_q      <= rnd_d;
            out_data_q <= out_data_d;
            out_dec_q  <= out_dec_d;
        end
    end

endmodule

// File: tb/tb_aes_core_iter.sv
// Scoreboard bench for aes_core_iter: Nk=4 instance under full handshake/reset stimulus,
// plus Nk=6 and Nk=8 instances checked for setup length, latency and known-answer result.
module tb_aes_core_iter;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] K6  = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K8  =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT8 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_b, key_load, key_ready, in_valid, in_ready, in_decrypt;
    logic         out_valid, out_ready, out_decrypt;
    logic [127:0] key, in_data, out_data;

    aes_core_iter #(.Nk(4)) u_dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .key_load   (key_load),
        .key        (key),
        .key_ready  (key_ready),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_decrypt (in_decrypt),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_decrypt(out_decrypt),
        .out_data   (out_data)
    );

    // Index 0: Nk=6 instance, index 1: Nk=8 instance.
    logic         x_kl [2], x_kr [2], x_iv [2], x_ird [2], x_idec [2];
    logic         x_ov [2], x_ordy [2], x_odec [2];
    logic [255:0] x_key [2];
    logic [127:0] x_idata [2], x_odata [2];

    aes_core_iter #(.Nk(6)) u_dut6 (
        .clk        (clk),
        .rst_b      (rst_b),
        .key_load   (x_kl[0]),
        .key        (x_key[0][191:0]),
        .key_ready  (x_kr[0]),
        .in_valid   (x_iv[0]),
        .in_ready   (x_ird[0]),
        .in_decrypt (x_idec[0]),
        .in_data    (x_idata[0]),
        .out_valid  (x_ov[0]),
        .out_ready  (x_ordy[0]),
        .out_decrypt(x_odec[0]),
        .out_data   (x_odata[0])
    );

    aes_core_iter #(.Nk(8)) u_dut8 (
        .clk        (clk),
        .rst_b      (rst_b),
        .key_load   (x_kl[1]),
        .key        (x_key[1]),
        .key_ready  (x_kr[1]),
        .in_valid   (x_iv[1]),
        .in_ready   (x_ird[1]),
        .in_decrypt (x_idec[1]),
        .in_data    (x_idata[1]),
        .out_valid  (x_ov[1]),
        .out_ready  (x_ordy[1]),
        .out_decrypt(x_odec[1]),
        .out_data   (x_odata[1])
    );

    typedef struct {
        logic         dec;
        logic [127:0] data;
        int           acc;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic ov_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Output side of the scoreboard: latency on each rising out_valid, data on each handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_b) begin
            if (out_valid && !ov_prev && sb_q.size() > 0)
                check_eq("latency", 128'(cyc - sb_q[0].acc), 128'd10);
            if (out_valid && out_ready) begin
                check_eq("sb_nonempty", 128'(sb_q.size() > 0), 128'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check_eq("out_data", out_data, e.data);
                    check_eq("out_decrypt", 128'(out_decrypt), 128'(e.dec));
                end
            end
        end
        ov_prev <= out_valid;
    end

    task automatic load_key(input logic [127:0] k, output int cycles);
        @(posedge clk); #1;
        key_load = 1'b1;
        key      = k;
        @(posedge clk); #1;
        key_load = 1'b0;
        cycles   = 0;
        while (!key_ready && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic send(input logic dec, input logic [127:0] d, input logic [127:0] exp,
                        output int acc);
        exp_t e;
        int   n;
        in_decrypt = dec;
        in_data    = d;
        in_valid   = 1'b1;
        n          = 0;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept", 128'(in_ready), 128'd1);
        acc = cyc + 1;
        if (in_ready) begin
            e.dec  = dec;
            e.data = exp;
            e.acc  = acc;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() > 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("drain", 128'(sb_q.size()), 128'd0);
    endtask

    task automatic run_x(input int n, input logic [255:0] k, input logic [127:0] exp,
                         input int exp_setup, input int exp_lat);
        int c;
        @(posedge clk); #1;
        x_kl[n]  = 1'b1;
        x_key[n] = k;
        @(posedge clk); #1;
        x_kl[n] = 1'b0;
        c = 0;
        while (!x_kr[n] && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        check_eq($sformatf("setup_x%0d", n), 128'(c), 128'(exp_setup));
        x_idata[n] = PT;
        x_idec[n]  = 1'b0;
        x_iv[n]    = 1'b1;
        x_ordy[n]  = 1'b1;
        @(negedge clk);
        check_eq($sformatf("in_ready_x%0d", n), 128'(x_ird[n]), 128'd1);
        @(posedge clk); #1;
        x_iv[n] = 1'b0;
        c = 0;
        while (!x_ov[n] && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        check_eq($sformatf("latency_x%0d", n), 128'(c), 128'(exp_lat));
        check_eq($sformatf("data_x%0d", n), x_odata[n], exp);
        check_eq($sformatf("decrypt_x%0d", n), 128'(x_odec[n]), 128'd0);
    endtask

    initial begin
        int   n, a1, a2, seen;
        exp_t e;
        rst_b      = 1'b0;
        key_load   = 1'b0;
        key        = '0;
        in_valid   = 1'b1;
        in_decrypt = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            x_kl[i]    = 1'b0;
            x_key[i]   = '0;
            x_iv[i]    = 1'b0;
            x_idec[i]  = 1'b0;
            x_idata[i] = '0;
            x_ordy[i]  = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_key_ready", 128'(key_ready), 128'd0);
        check_eq("rst_in_ready", 128'(in_ready), 128'd0);
        check_eq("rst_out_valid", 128'(out_valid), 128'd0);
        check_eq("rst_out_decrypt", 128'(out_decrypt), 128'd0);
        check_eq("rst_out_data", out_data, 128'd0);
        in_valid = 1'b0;
        rst_b    = 1'b1;

        // Basic encrypt / decrypt with FIPS-197 AES-128 vector.
        load_key(K1, n);
        check_eq("setup4", 128'(n), 128'd40);
        send(1'b0, PT, CT, a1);
        drain();
        send(1'b1, CT, PT, a1);
        drain();

        // Back-to-back: one block every Nr+1 cycles.
        send(1'b0, PT, CT, a1);
        send(1'b1, CT, PT, a2);
        check_eq("throughput", 128'(a2 - a1), 128'd11);
        drain();

        // Backpressure for 20 cycles with a new block waiting.
        out_ready = 1'b0;
        send(1'b0, PT, CT, a1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid   = 1'b1;
        in_decrypt = 1'b1;
        in_data    = CT;
        repeat (20) begin
            @(negedge clk);
            check_eq("bp_valid", 128'(out_valid), 128'd1);
            check_eq("bp_data", out_data, CT);
            check_eq("bp_in_ready", 128'(in_ready), 128'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("both_hs_in", 128'(in_ready), 128'd1);
        check_eq("both_hs_out", 128'(out_valid), 128'd1);
        e.dec  = 1'b1;
        e.data = PT;
        e.acc  = cyc + 1;
        sb_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // key_load during RUN is ignored.
        send(1'b0, PT, CT, a1);
        repeat (3) @(posedge clk);
        #1;
        key_load = 1'b1;
        key      = K2;
        @(posedge clk); #1;
        key_load = 1'b0;
        check_eq("run_kl_key_ready", 128'(key_ready), 128'd1);
        drain();
        send(1'b0, PT, CT, a1);
        drain();

        // key_load beats in_valid in IDLE and restarts setup.
        @(posedge clk); #1;
        key_load   = 1'b1;
        key        = K2;
        in_valid   = 1'b1;
        in_decrypt = 1'b0;
        in_data    = PT2;
        @(negedge clk);
        check_eq("kl_wins_in_ready", 128'(in_ready), 128'd0);
        @(posedge clk); #1;
        key_load = 1'b0;
        in_valid = 1'b0;
        check_eq("kl_key_ready_drop", 128'(key_ready), 128'd0);
        n = 0;
        while (!key_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("setup_reload", 128'(n), 128'd40);
        send(1'b0, PT2, CT2, a1);
        drain();
        send(1'b1, CT2, PT2, a1);
        drain();

        // key_load mid-KEYSETUP restarts with the new key.
        @(posedge clk); #1;
        key_load = 1'b1;
        key      = K1;
        @(posedge clk); #1;
        key_load = 1'b0;
        repeat (10) @(posedge clk);
        load_key(K2, n);
        check_eq("setup_restart", 128'(n), 128'd40);
        send(1'b0, PT2, CT2, a1);
        drain();

        // AES-192 and AES-256 instances.
        run_x(0, K6, CT6, 46, 12);
        run_x(1, K8, CT8, 52, 14);

        // Reset mid-KEYSETUP.
        @(posedge clk); #1;
        key_load = 1'b1;
        key      = K1;
        @(posedge clk); #1;
        key_load = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_b = 1'b0;
        #1;
        check_eq("rks_key_ready", 128'(key_ready), 128'd0);
        check_eq("rks_in_ready", 128'(in_ready), 128'd0);
        check_eq("rks_out_valid", 128'(out_valid), 128'd0);
        check_eq("rks_out_decrypt", 128'(out_decrypt), 128'd0);
        check_eq("rks_out_data", out_data, 128'd0);
        @(posedge clk); #1;
        rst_b    = 1'b1;
        in_valid = 1'b1;
        in_data  = PT;
        repeat (5) begin
            @(negedge clk);
            check_eq("nokey_in_ready", 128'(in_ready), 128'd0);
        end
        in_valid = 1'b0;
        load_key(K1, n);
        check_eq("setup_after_rst", 128'(n), 128'd40);
        send(1'b1, CT, PT, a1);
        drain();

        // Reset mid-RUN: no partial result, outputs cleared.
        send(1'b0, PT, CT, a1);
        repeat (4) @(posedge clk);
        #1;
        rst_b = 1'b0;
        sb_q.delete();
        #1;
        check_eq("rrun_key_ready", 128'(key_ready), 128'd0);
        check_eq("rrun_in_ready", 128'(in_ready), 128'd0);
        check_eq("rrun_out_valid", 128'(out_valid), 128'd0);
        check_eq("rrun_out_decrypt", 128'(out_decrypt), 128'd0);
        check_eq("rrun_out_data", out_data, 128'd0);
        @(posedge clk); #1;
        rst_b = 1'b1;
        seen  = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid || in_ready || key_ready) seen = 1;
        end
        check_eq("rrun_quiet", 128'(seen), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
